char_loader: RTL and testbench
==============================

Name: char_loader

Overview:
Writer side of the character glyph BRAM. It receives a framed byte stream over a valid/ready interface, such as one coming from a UART receiver. It assembles 16-bit glyph words and drives the BRAM write port (wr_en/waddr/data_in) at sequential addresses. This block populates glyph memory that the display path later reads; it reports frame completion, checksum failures and stalled frames.

Parameters:
MEMWIDTH, 8, BRAM address width; legal range 1..8; address byte truncated to low MEMWIDTH bits.
TIMEOUT, 1000, max idle cycles allowed between accepted bytes inside a frame; legal range 2..65535.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  in_data holds a byte
in_ready  output  1  block can accept a byte; transfer occurs when in_valid & in_ready at a rising edge
in_data  input  8  stream byte
wr_en  output  1  BRAM write strobe, one cycle per word
waddr  output  MEMWIDTH  BRAM write address
wdata  output  16  BRAM write data
busy  output  1  high while a frame is in progress (state != IDLE)
done  output  1  one-cycle pulse: frame finished with good checksum
err  output  1  one-cycle pulse: frame aborted or bad
err_code  output  2  valid when err=1: 2'd1 checksum mismatch, 2'd2 timeout; holds its last value otherwise

Behaviour:
- Frame format: 0xA5, ADDR, LEN, then LEN×(HI, LO) data bytes, then CSUM. LEN=0 means 256 words.
- CSUM = 8-bit sum (mod 256) of all data bytes only.
- States: IDLE, ADDR, LEN, DHI, DLO, CSUM. State advances only on an accepted byte.
- IDLE: 0xA5 moves to ADDR. Any other byte is accepted and discarded with no flag.
- ADDR: latch ADDR[MEMWIDTH-1:0] into the address counter, go to LEN.
- LEN: latch word count, clear running sum, go to DHI.
- DHI: hold byte as the high half, add it to the sum, go to DLO.
- DLO: add byte to the sum and decrement the word count. Go to CSUM when the count is exhausted; otherwise go to DHI.
- Write timing: the LO byte is accepted at edge k. In the cycle after k: wr_en=1, wdata={HI,LO}, waddr=current address. The address counter then increments modulo 2^MEMWIDTH, so writes wrap from max to 0.
- Writes are not rolled back on a later checksum failure.
- CSUM: compare the byte with the running sum, return to IDLE. In the cycle after acceptance, pulse done=1 on a match; on a mismatch pulse err=1 with err_code=1.
- Timeout: an idle counter clears on every accepted byte and is held at 0 in IDLE. It counts cycles with no accepted byte while in ADDR through CSUM.
  - When it reaches TIMEOUT, go to IDLE and pulse err=1 with err_code=2 on the next cycle. No write is issued.
  - If a byte is accepted on the same edge the counter would expire, the byte wins and there is no timeout.
- in_ready: 0 during reset and in the cycle immediately after reset deasserts. It is 1 at all other times; the block never stalls the sender.
- Reset values: in_ready=0, wr_en=0, waddr=0, wdata=0, busy=0, done=0, err=0, err_code=0, state=IDLE, counters=0.
- Reset mid-frame discards the frame entirely. No write, done or err is produced for it.
- done and err are never asserted in the same cycle. wr_en never coincides with done or err.
- All outputs are registered.

Test Plan:
- Good frame: after reset, stream A5 10 02 12 34 56 78 14 back-to-back → writes addr 0x10=0x1234 then 0x11=0x5678. Each wr_en is one cycle, arriving one cycle after byte 0x34 and byte 0x78 respectively. done pulses once after 0x14; err stays 0.
- Checksum error: A5 20 01 AB CD 00 → one write, 0x20=0xABCD. Then err=1 with err_code=1 for one cycle; done stays 0.
- Wrap and LEN=0: A5 FE 00 followed by 512 data bytes → 256 writes at 0xFE, 0xFF, 0x00 … 0xFD. With a correct CSUM, done pulses once.
- Timeout: A5 30 01 11, then no valid for TIMEOUT cycles → no write, err pulses with err_code=2, busy drops. A following good frame completes normally.
- Garbage and gaps: bytes 00 FF 5A before A5, and in_valid toggled randomly inside a frame with gaps < TIMEOUT → pre-header bytes ignored, writes and done identical to the back-to-back case.
- Reset mid-frame: assert rst after A5 40 02 12 → all outputs at reset values, no write or pulses. The next complete frame writes from its own ADDR.

Source files
------------

// File: rtl/char_loader_if.sv
// Byte-stream input, glyph BRAM write port and frame status of the glyph loader.
interface char_loader_if #(
  parameter int unsigned MEMWIDTH = 8
);
  logic                in_valid;
  logic                in_ready;
  logic [7:0]          in_data;
  logic                wr_en;
  logic [MEMWIDTH-1:0] waddr;
  logic [15:0]         wdata;
  logic                busy;
  logic                done;
  logic                err;
  logic [1:0]          err_code;

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, waddr, wdata, busy, done, err, err_code
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, waddr, wdata, busy, done, err, err_code
  );
endinterface

// File: rtl/char_loader.sv
// Glyph BRAM writer: parses A5/ADDR/LEN/(HI,LO)*/CSUM frames into sequential 16-bit writes.
module char_loader #(
  parameter int unsigned MEMWIDTH = 8,
  parameter int unsigned TIMEOUT  = 1000
) (
  input logic          clk,
  input logic          rst,
  char_loader_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StAddr, StLen, StDhi, StDlo, StCsum} state_e;

  state_e              state_q, state_d;
  logic [MEMWIDTH-1:0] addr_q, addr_d;
  logic [8:0]          cnt_q, cnt_d;
  logic [7:0]          sum_q, sum_d;
  logic [7:0]          hi_q, hi_d;
  logic [15:0]         idle_q, idle_d;
  logic                ready_q;
  logic                wr_en_q, wr_en_d;
  logic [MEMWIDTH-1:0] waddr_q, waddr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic                busy_q;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;
  logic                accept;

  assign accept = bus.in_valid & ready_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    hi_d       = hi_q;
    idle_d     = idle_q;
    wr_en_d    = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    // An accepted byte always beats an expiring idle counter.
    if (state_q == StIdle || accept) begin
      idle_d = '0;
    end else if (idle_q == 16'(TIMEOUT - 1)) begin
      state_d    = StIdle;
      idle_d     = '0;
      err_d      = 1'b1;
      err_code_d = 2'd2;
    end else begin
      idle_d = idle_q + 16'd1;
    end

    if (accept) begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_data == 8'hA5) state_d = StAddr;
        end
        StAddr: begin
          addr_d  = bus.in_data[MEMWIDTH-1:0];
          state_d = StLen;
        end
        StLen: begin
          cnt_d   = (bus.in_data == 8'h00) ? 9'd256 : {1'b0, bus.in_data};
          sum_d   = 8'h00;
          state_d = StDhi;
        end
        StDhi: begin
          hi_d    = bus.in_data;
          sum_d   = sum_q + bus.in_data;
          state_d = StDlo;
        end
        StDlo: begin
          sum_d   = sum_q + bus.in_data;
          cnt_d   = cnt_q - 9'd1;
          wr_en_d = 1'b1;
          wdata_d = {hi_q, bus.in_data};
          waddr_d = addr_q;
          addr_d  = addr_q + 1'b1;
          state_d = (cnt_q == 9'd1) ? StCsum : StDhi;
        end
        StCsum: begin
          if (bus.in_data == sum_q) begin
            done_d = 1'b1;
          end else begin
            err_d      = 1'b1;
            err_code_d = 2'd1;
          end
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      cnt_q      <= '0;
      sum_q      <= '0;
      hi_q       <= '0;
      idle_q     <= '0;
      ready_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      hi_q       <= hi_d;
      idle_q     <= idle_d;
      ready_q    <= 1'b1;
      wr_en_q    <= wr_en_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      busy_q     <= (state_d != StIdle);
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign bus.in_ready = ready_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.waddr    = waddr_q;
  assign bus.wdata    = wdata_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.err_code = err_code_q;

endmodule

// File: tb/tb_char_loader.sv
// Directed bench for char_loader: frame parsing, writes, checksum, timeout and reset.
module tb_char_loader;
  localparam int unsigned MW = 8;
  localparam int unsigned TO = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  char_loader_if #(.MEMWIDTH(MW)) bus ();

  char_loader #(.MEMWIDTH(MW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_acc = 0;

  // Cycle n is the interval following rising edge n.
  always @(posedge clk) cyc <= cyc + 1;

  logic [MW-1:0] wa_q[$];
  logic [15:0]   wd_q[$];
  int            wc_q[$];
  int            done_n = 0, err_n = 0, overlap_n = 0;
  int            done_cyc = -1, err_cyc = -1;
  logic [1:0]    err_code_seen = 2'd0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wr_en) begin
        wa_q.push_back(bus.waddr);
        wd_q.push_back(bus.wdata);
        wc_q.push_back(cyc);
      end
      if (bus.done) begin
        done_n++;
        done_cyc = cyc;
      end
      if (bus.err) begin
        err_n++;
        err_cyc = cyc;
        err_code_seen = bus.err_code;
      end
      if ((bus.done && bus.err) || (bus.wr_en && (bus.done || bus.err))) overlap_n++;
    end
  end

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    done_n = 0;
    err_n = 0;
    done_cyc = -1;
    err_cyc = -1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    last_acc = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_cycles(3);
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got=%b want=0", bus.in_ready); end
    n_cmp++; if (bus.wr_en !== 1'b0) begin n_bad++; $display("FAIL rst_wr_en got=%b want=0", bus.wr_en); end
    n_cmp++; if (bus.waddr !== 8'h00) begin n_bad++; $display("FAIL rst_waddr got=%h want=00", bus.waddr); end
    n_cmp++; if (bus.wdata !== 16'h0000) begin n_bad++; $display("FAIL rst_wdata got=%h want=0000", bus.wdata); end
    n_cmp++; if ({bus.busy, bus.done, bus.err} !== 3'b000) begin n_bad++; $display("FAIL rst_flags got=%b want=000", {bus.busy, bus.done, bus.err}); end
    n_cmp++; if (bus.err_code !== 2'd0) begin n_bad++; $display("FAIL rst_err_code got=%0d want=0", bus.err_code); end
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL ready_after_rst got=%b want=0", bus.in_ready); end
    idle_cycles(1);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL ready_up got=%b want=1", bus.in_ready); end
  endtask

  task automatic test_good_frame();
    int acc34, acc78, acccs;
    clear_log();
    send(8'hA5); send(8'h10); send(8'h02); send(8'h12);
    send(8'h34); acc34 = last_acc;
    send(8'h56);
    send(8'h78); acc78 = last_acc;
    send(8'h14); acccs = last_acc;
    idle_cycles(3);
    n_cmp++; if (wa_q.size() !== 2) begin n_bad++; $display("FAIL good_nwr got=%0d want=2", wa_q.size()); end
    if (wa_q.size() == 2) begin
      n_cmp++; if (wa_q[0] !== 8'h10 || wd_q[0] !== 16'h1234) begin n_bad++; $display("FAIL good_wr0 got=%h:%h want=10:1234", wa_q[0], wd_q[0]); end
      n_cmp++; if (wa_q[1] !== 8'h11 || wd_q[1] !== 16'h5678) begin n_bad++; $display("FAIL good_wr1 got=%h:%h want=11:5678", wa_q[1], wd_q[1]); end
      n_cmp++; if (wc_q[0] !== acc34) begin n_bad++; $display("FAIL good_wr0_time got=%0d want=%0d", wc_q[0], acc34); end
      n_cmp++; if (wc_q[1] !== acc78) begin n_bad++; $display("FAIL good_wr1_time got=%0d want=%0d", wc_q[1], acc78); end
    end
    n_cmp++; if (done_n !== 1) begin n_bad++; $display("FAIL good_done_n got=%0d want=1", done_n); end
    n_cmp++; if (done_cyc !== acccs) begin n_bad++; $display("FAIL good_done_time got=%0d want=%0d", done_cyc, acccs); end
    n_cmp++; if (err_n !== 0) begin n_bad++; $display("FAIL good_err_n got=%0d want=0", err_n); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL good_busy got=%b want=0", bus.busy); end
  endtask

  task automatic test_csum_error();
    clear_log();
    send(8'hA5); send(8'h20); send(8'h01); send(8'hAB); send(8'hCD); send(8'h00);
    idle_cycles(3);
    n_cmp++; if (wa_q.size() !== 1) begin n_bad++; $display("FAIL csum_nwr got=%0d want=1", wa_q.size()); end
    if (wa_q.size() == 1) begin
      n_cmp++; if (wa_q[0] !== 8'h20 || wd_q[0] !== 16'hABCD) begin n_bad++; $display("FAIL csum_wr got=%h:%h want=20:abcd", wa_q[0], wd_q[0]); end
    end
    n_cmp++; if (err_n !== 1 || err_code_seen !== 2'd1) begin n_bad++; $display("FAIL csum_err got=%0d/%0d want=1/1", err_n, err_code_seen); end
    n_cmp++; if (done_n !== 0) begin n_bad++; $display("FAIL csum_done got=%0d want=0", done_n); end
    n_cmp++; if (bus.err !== 1'b0 || bus.err_code !== 2'd1) begin n_bad++; $display("FAIL csum_code_hold got=%b/%0d want=0/1", bus.err, bus.err_code); end
  endtask

  task automatic test_wrap_len0();
    logic [7:0] sum;
    logic [7:0] hi, lo;
    int bad;
    clear_log();
    sum = 8'h00;
    send(8'hA5); send(8'hFE); send(8'h00);
    for (int i = 0; i < 256; i++) begin
      hi = 8'(i);
      lo = 8'(i) ^ 8'h5A;
      sum = sum + hi + lo;
      send(hi);
      send(lo);
    end
    send(sum);
    idle_cycles(3);
    n_cmp++; if (wa_q.size() !== 256) begin n_bad++; $display("FAIL wrap_nwr got=%0d want=256", wa_q.size()); end
    if (wa_q.size() == 256) begin
      bad = 0;
      for (int i = 0; i < 256; i++) begin
        hi = 8'(i);
        lo = 8'(i) ^ 8'h5A;
        n_cmp++;
        if (wa_q[i] !== 8'(8'hFE + i) || wd_q[i] !== {hi, lo}) begin
          n_bad++;
          if (bad < 4) $display("FAIL wrap_wr%0d got=%h:%h want=%h:%h", i, wa_q[i], wd_q[i], 8'(8'hFE + i), {hi, lo});
          bad++;
        end
      end
    end
    n_cmp++; if (done_n !== 1 || err_n !== 0) begin n_bad++; $display("FAIL wrap_done got=%0d/%0d want=1/0", done_n, err_n); end
  endtask

  task automatic test_timeout();
    int acc;
    clear_log();
    send(8'hA5); send(8'h30); send(8'h01); send(8'h11);
    acc = last_acc;
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL to_busy_before got=%b want=1", bus.busy); end
    idle_cycles(TO + 5);
    n_cmp++; if (err_n !== 1 || err_code_seen !== 2'd2) begin n_bad++; $display("FAIL to_err got=%0d/%0d want=1/2", err_n, err_code_seen); end
    n_cmp++; if (err_cyc !== acc + TO) begin n_bad++; $display("FAIL to_time got=%0d want=%0d", err_cyc, acc + TO); end
    n_cmp++; if (wa_q.size() !== 0) begin n_bad++; $display("FAIL to_nwr got=%0d want=0", wa_q.size()); end
    n_cmp++; if (bus.busy !== 1'b0 || done_n !== 0) begin n_bad++; $display("FAIL to_after got=%b/%0d want=0/0", bus.busy, done_n); end
    clear_log();
    send(8'hA5); send(8'h10); send(8'h02); send(8'h12);
    send(8'h34); send(8'h56); send(8'h78); send(8'h14);
    idle_cycles(3);
    n_cmp++; if (wa_q.size() !== 2 || done_n !== 1 || err_n !== 0) begin n_bad++; $display("FAIL to_next got=%0d/%0d/%0d want=2/1/0", wa_q.size(), done_n, err_n); end
  endtask

  task automatic test_gaps();
    logic [7:0] frame [8];
    frame = '{8'hA5, 8'h10, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h14};
    clear_log();
    send(8'h00); send(8'hFF); send(8'h5A);
    for (int i = 0; i < 8; i++) begin
      idle_cycles(int'($urandom_range(0, 4)));
      send(frame[i]);
    end
    idle_cycles(3);
    n_cmp++; if (wa_q.size() !== 2) begin n_bad++; $display("FAIL gap_nwr got=%0d want=2", wa_q.size()); end
    if (wa_q.size() == 2) begin
      n_cmp++; if (wa_q[0] !== 8'h10 || wd_q[0] !== 16'h1234) begin n_bad++; $display("FAIL gap_wr0 got=%h:%h want=10:1234", wa_q[0], wd_q[0]); end
      n_cmp++; if (wa_q[1] !== 8'h11 || wd_q[1] !== 16'h5678) begin n_bad++; $display("FAIL gap_wr1 got=%h:%h want=11:5678", wa_q[1], wd_q[1]); end
    end
    n_cmp++; if (done_n !== 1 || err_n !== 0) begin n_bad++; $display("FAIL gap_done got=%0d/%0d want=1/0", done_n, err_n); end
  endtask

  task automatic test_reset_mid();
    clear_log();
    send(8'hA5); send(8'h40); send(8'h02); send(8'h12);
    rst = 1'b1;
    idle_cycles(2);
    n_cmp++; if ({bus.in_ready, bus.wr_en, bus.busy, bus.done, bus.err} !== 5'b0) begin n_bad++; $display("FAIL mid_flags got=%b want=00000", {bus.in_ready, bus.wr_en, bus.busy, bus.done, bus.err}); end
    n_cmp++; if (bus.waddr !== 8'h00 || bus.wdata !== 16'h0000 || bus.err_code !== 2'd0) begin n_bad++; $display("FAIL mid_regs got=%h/%h/%0d want=00/0000/0", bus.waddr, bus.wdata, bus.err_code); end
    rst = 1'b0;
    idle_cycles(2);
    send(8'hA5); send(8'h50); send(8'h01); send(8'h0A); send(8'h0B); send(8'h15);
    idle_cycles(3);
    n_cmp++; if (wa_q.size() !== 1) begin n_bad++; $display("FAIL mid_nwr got=%0d want=1", wa_q.size()); end
    if (wa_q.size() == 1) begin
      n_cmp++; if (wa_q[0] !== 8'h50 || wd_q[0] !== 16'h0A0B) begin n_bad++; $display("FAIL mid_wr got=%h:%h want=50:0a0b", wa_q[0], wd_q[0]); end
    end
    n_cmp++; if (done_n !== 1 || err_n !== 0) begin n_bad++; $display("FAIL mid_done got=%0d/%0d want=1/0", done_n, err_n); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    test_reset();
    test_good_frame();
    test_csum_error();
    test_wrap_len0();
    test_timeout();
    test_gaps();
    test_reset_mid();
    n_cmp++; if (overlap_n !== 0) begin n_bad++; $display("FAIL pulse_overlap got=%0d want=0", overlap_n); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
